// File: rtl/wb_arbiter.sv
// Write-back arbiter that owns the register-file write port. ALU results always win the port.
// Long-latency results queue in an in-order FIFO and drain into idle cycles; a bypass lookup exposes pending values.
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [4:0]               lsu_rd,
   input  logic [XLEN-1:0]          lsu_data,
   output logic                     rf_en,
   output logic [4:0]               rf_wa,
   output logic [XLEN-1:0]          rf_wd,
   input  logic [4:0]               byp_addr,
   output logic                     byp_hit,
   output logic [XLEN-1:0]          byp_data,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DEPTH-1:0] valid_r;
   logic [DEPTH-1:0] killed_r;
   logic [4:0]       rd_r   [DEPTH];
   logic [XLEN-1:0]  data_r [DEPTH];
   logic [AW-1:0]    rptr_r;
   logic [AW-1:0]    wptr_r;
   logic [CW-1:0]    count_r;

   logic             alu_req_s;
   logic             push_s;
   logic             pop_s;
   logic             fifo_hit_s;
   logic [XLEN-1:0]  fifo_data_s;
   logic [AW-1:0]    idx_s;

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
   assign lsu_ready = !rst && (count_r < DEPTH_C);
   assign occupancy = count_r;
   assign alu_req_s = alu_valid && (alu_rd != 5'd0);
   assign push_s    = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
   assign pop_s     = !alu_req_s && (count_r != {CW{1'b0}});

   // Write-port register: ALU first, then the FIFO head, else idle with address/data held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_en <= 1'b0;
         rf_wa <= 5'd0;
         rf_wd <= {XLEN{1'b0}};
      end else if (alu_req_s) begin
         rf_en <= 1'b1;
         rf_wa <= alu_rd;
         rf_wd <= alu_data;
      end else if (pop_s) begin
         rf_en <= !killed_r[rptr_r];
         if (!killed_r[rptr_r]) begin
            rf_wa <= rd_r[rptr_r];
            rf_wd <= data_r[rptr_r];
         end
      end else begin
         rf_en <= 1'b0;
      end
   end

   // FIFO control state: kill matching entries on ALU writes, then retire the head and append the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r  <= {DEPTH{1'b0}};
         killed_r <= {DEPTH{1'b0}};
         rptr_r   <= {AW{1'b0}};
         wptr_r   <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_req_s && valid_r[i] && (rd_r[i] == alu_rd)) begin
               killed_r[i] <= 1'b1;
            end
         end
         if (pop_s) begin
            valid_r[rptr_r] <= 1'b0;
            rptr_r          <= rptr_r + AW'(1);
         end
         // The new entry is already stale if the ALU writes the same register at this edge.
         if (push_s) begin
            valid_r[wptr_r]  <= 1'b1;
            killed_r[wptr_r] <= alu_req_s && (lsu_rd == alu_rd);
            wptr_r           <= wptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO payload storage; validity is tracked separately, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         rd_r[wptr_r]   <= lsu_rd;
         data_r[wptr_r] <= lsu_data;
      end
   end

   // Bypass search: scan oldest to youngest so the youngest live match is the one left standing.
   always_comb begin
      fifo_hit_s  = 1'b0;
      fifo_data_s = {XLEN{1'b0}};
      idx_s       = rptr_r;
      for (int i = 0; i < DEPTH; i++) begin
         idx_s = rptr_r + AW'(i);
         if (valid_r[idx_s] && !killed_r[idx_s] && (rd_r[idx_s] == byp_addr)) begin
            fifo_hit_s  = 1'b1;
            fifo_data_s = data_r[idx_s];
         end else begin
            fifo_hit_s  = fifo_hit_s;
            fifo_data_s = fifo_data_s;
         end
      end
   end

   // Bypass result: FIFO entries are younger than the output register.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = {XLEN{1'b0}};
      if (rst || (byp_addr == 5'd0)) begin
         byp_hit  = 1'b0;
         byp_data = {XLEN{1'b0}};
      end else if (fifo_hit_s) begin
         byp_hit  = 1'b1;
         byp_data = fifo_data_s;
      end else if (rf_en && (rf_wa == byp_addr)) begin
         byp_hit  = 1'b1;
         byp_data = rf_wd;
      end else begin
         byp_hit  = 1'b0;
         byp_data = {XLEN{1'b0}};
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (DEPTH=4, XLEN=32) plus an asynchronous-reset sequence.
module tb_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        rf_en;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [4:0]  byp_addr;
   logic        byp_hit;
   logic [31:0] byp_data;
   logic [2:0]  occupancy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic [4:0]  ba;
      logic        en;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rdy;
      logic [2:0]  occ;
      logic        hit;
      logic [31:0] bd;
   } vec_t;

   vec_t vecs[$];

   wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .rf_en(rf_en), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] ba);
      alu_valid = av;  alu_rd = ard;  alu_data = ad;
      lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
      byp_addr  = ba;
   endtask

   task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [4:0] ba, input logic en, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rdy, input logic [2:0] occ,
                      input logic hit, input logic [31:0] bd);
      vec_t v;
      v.av = av;  v.ard = ard;  v.ad = ad;  v.lv = lv;  v.lrd = lrd;  v.ld = ld;  v.ba = ba;
      v.en = en;  v.wa = wa;    v.wd = wd;  v.rdy = rdy; v.occ = occ; v.hit = hit; v.bd = bd;
      vecs.push_back(v);
   endtask

   initial begin
      // ALU single write, then idle
      add(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5,  1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 3'd0, 1'b1, 32'hDEADBEEF);
      add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd5,  1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 3'd0, 1'b0, 32'h0);
      // back-to-back LSU pushes with ALU idle
      add(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h11, 5'd1,  1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 3'd1, 1'b1, 32'h11);
      add(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22, 5'd1,  1'b1, 5'd1, 32'h11, 1'b1, 3'd1, 1'b1, 32'h11);
      add(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 5'd2,  1'b1, 5'd2, 32'h22, 1'b1, 3'd1, 1'b1, 32'h22);
      add(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 5'd3,  1'b1, 5'd3, 32'h33, 1'b1, 3'd1, 1'b1, 32'h33);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  5'd4,  1'b1, 5'd4, 32'h44, 1'b1, 3'd0, 1'b1, 32'h44);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  5'd4,  1'b0, 5'd4, 32'h44, 1'b1, 3'd0, 1'b0, 32'h0);
      // fill under continuous ALU traffic; fifth offer refused while full
      add(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB1, 5'd11,  1'b1, 5'd10, 32'hA0, 1'b1, 3'd1, 1'b1, 32'hB1);
      add(1'b1, 5'd10, 32'hA1, 1'b1, 5'd12, 32'hB2, 5'd12,  1'b1, 5'd10, 32'hA1, 1'b1, 3'd2, 1'b1, 32'hB2);
      add(1'b1, 5'd10, 32'hA2, 1'b1, 5'd13, 32'hB3, 5'd13,  1'b1, 5'd10, 32'hA2, 1'b1, 3'd3, 1'b1, 32'hB3);
      add(1'b1, 5'd10, 32'hA3, 1'b1, 5'd14, 32'hB4, 5'd14,  1'b1, 5'd10, 32'hA3, 1'b0, 3'd4, 1'b1, 32'hB4);
      add(1'b1, 5'd10, 32'hA4, 1'b1, 5'd15, 32'hB5, 5'd15,  1'b1, 5'd10, 32'hA4, 1'b0, 3'd4, 1'b0, 32'h0);
      // drain in order once the ALU stops
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11,  1'b1, 5'd11, 32'hB1, 1'b1, 3'd3, 1'b1, 32'hB1);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13,  1'b1, 5'd12, 32'hB2, 1'b1, 3'd2, 1'b1, 32'hB3);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13,  1'b1, 5'd13, 32'hB3, 1'b1, 3'd1, 1'b1, 32'hB3);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd14,  1'b1, 5'd14, 32'hB4, 1'b1, 3'd0, 1'b1, 32'hB4);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd14,  1'b0, 5'd14, 32'hB4, 1'b1, 3'd0, 1'b0, 32'h0);
      // kill of an older queued entry by a newer ALU write
      add(1'b1, 5'd9, 32'h90, 1'b1, 5'd7, 32'h1, 5'd7,  1'b1, 5'd9, 32'h90, 1'b1, 3'd1, 1'b1, 32'h1);
      add(1'b1, 5'd7, 32'h2,  1'b0, 5'd0, 32'h0, 5'd7,  1'b1, 5'd7, 32'h2,  1'b1, 3'd1, 1'b1, 32'h2);
      add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd7,  1'b0, 5'd7, 32'h2,  1'b1, 3'd0, 1'b0, 32'h0);
      // kill of an entry pushed at the same edge
      add(1'b1, 5'd8, 32'h80, 1'b1, 5'd8, 32'h81, 5'd8,  1'b1, 5'd8, 32'h80, 1'b1, 3'd1, 1'b1, 32'h80);
      add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd8,  1'b0, 5'd8, 32'h80, 1'b1, 3'd0, 1'b0, 32'h0);
      // youngest-match bypass, then drain
      add(1'b1, 5'd20, 32'hC0, 1'b1, 5'd3, 32'hA, 5'd3,  1'b1, 5'd20, 32'hC0, 1'b1, 3'd1, 1'b1, 32'hA);
      add(1'b1, 5'd21, 32'hC1, 1'b1, 5'd3, 32'hB, 5'd3,  1'b1, 5'd21, 32'hC1, 1'b1, 3'd2, 1'b1, 32'hB);
      add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0, 5'd3,  1'b1, 5'd3,  32'hA,  1'b1, 3'd1, 1'b1, 32'hB);
      add(1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0, 5'd3,  1'b1, 5'd3,  32'hB,  1'b1, 3'd0, 1'b1, 32'hB);
      // rd==0 on both streams: no write, nothing enqueued
      add(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h55, 5'd0,  1'b0, 5'd3, 32'hB, 1'b1, 3'd0, 1'b0, 32'h0);
      // ALU rd==0 lets the FIFO drain
      add(1'b1, 5'd22, 32'hD0,  1'b1, 5'd4, 32'hE4, 5'd4,  1'b1, 5'd22, 32'hD0, 1'b1, 3'd1, 1'b1, 32'hE4);
      add(1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0, 32'h0, 5'd4,  1'b1, 5'd4,  32'hE4, 1'b1, 3'd0, 1'b1, 32'hE4);

      // reset state
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
      #2;
      chk("reset rf_en", {31'd0, rf_en}, 32'd0);
      chk("reset rf_wa", {27'd0, rf_wa}, 32'd0);
      chk("reset rf_wd", rf_wd, 32'd0);
      chk("reset occupancy", {29'd0, occupancy}, 32'd0);
      chk("reset lsu_ready", {31'd0, lsu_ready}, 32'd0);
      chk("reset byp_hit", {31'd0, byp_hit}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("post-reset lsu_ready", {31'd0, lsu_ready}, 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld, vecs[i].ba);
         tick();
         chk($sformatf("v%0d rf_en", i),     {31'd0, rf_en},     {31'd0, vecs[i].en});
         chk($sformatf("v%0d rf_wa", i),     {27'd0, rf_wa},     {27'd0, vecs[i].wa});
         chk($sformatf("v%0d rf_wd", i),     rf_wd,              vecs[i].wd);
         chk($sformatf("v%0d lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].rdy});
         chk($sformatf("v%0d occupancy", i), {29'd0, occupancy}, {29'd0, vecs[i].occ});
         chk($sformatf("v%0d byp_hit", i),   {31'd0, byp_hit},   {31'd0, vecs[i].hit});
         chk($sformatf("v%0d byp_data", i),  byp_data,           vecs[i].bd);
      end

      // asynchronous reset with three entries queued and a write in flight
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 5'd10, 32'h100 + i, 1'b1, 5'(i), 32'h200 + i, 5'd10);
         tick();
      end
      chk("pre-async occupancy", {29'd0, occupancy}, 32'd3);
      chk("pre-async rf_en", {31'd0, rf_en}, 32'd1);
      chk("pre-async byp_hit", {31'd0, byp_hit}, 32'd1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10);
      #2;
      rst = 1'b1;
      #1;
      chk("async rf_en", {31'd0, rf_en}, 32'd0);
      chk("async occupancy", {29'd0, occupancy}, 32'd0);
      chk("async lsu_ready", {31'd0, lsu_ready}, 32'd0);
      chk("async byp_hit", {31'd0, byp_hit}, 32'd0);
      tick();
      rst = 1'b0;
      byp_addr = 5'd1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("after-reset%0d rf_en", i), {31'd0, rf_en}, 32'd0);
         chk($sformatf("after-reset%0d occupancy", i), {29'd0, occupancy}, 32'd0);
         chk($sformatf("after-reset%0d byp_hit", i), {31'd0, byp_hit}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that sits directly upstream of the 32x32 register file and owns its single write port (`en`/`wa`/`wd`). It merges two result streams. The first is single-cycle ALU results, which always win the port. The second is long-latency load/mul-div results, which are buffered in a small in-order FIFO and drained into idle port cycles. It also supplies a bypass lookup so the decode stage can read values that are still pending and not yet committed.

## Interface
Parameters:
- `DEPTH`, 4: LSU result FIFO entries (power of two, ≥2)
- `XLEN`, 32: data width

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle (no back-pressure)
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `lsu_valid`  in  1  long-latency result offered
- `lsu_ready`  out  1  FIFO can accept; transfer on `lsu_valid && lsu_ready`
- `lsu_rd`  in  5  LSU destination register
- `lsu_data`  in  XLEN  LSU result
- `rf_en`  out  1  register-file write enable (registered)
- `rf_wa`  out  5  register-file write address (registered)
- `rf_wd`  out  XLEN  register-file write data (registered)
- `byp_addr`  in  5  bypass lookup address
- `byp_hit`  out  1  a live pending write to `byp_addr` exists
- `byp_data`  out  XLEN  youngest pending value for `byp_addr`
- `occupancy`  out  $clog2(DEPTH)+1  live plus killed entries held in the FIFO

## Operation
- FIFO entry fields: `{valid, killed, rd, data}`. Read and write pointers wrap modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
- `lsu_ready = !rst && (occupancy < DEPTH)`. Ready depends only on registered count. A pop in the same cycle does not free a slot early.
- LSU transfer with `lsu_rd == 0`: the handshake completes but nothing is enqueued.
- Port select at each posedge, in priority order:
  - ALU: `alu_valid && alu_rd != 0` loads `{rf_en,rf_wa,rf_wd} <= {1,alu_rd,alu_data}`.
  - Otherwise, if the FIFO is non-empty, pop the head. A head not killed gives `rf_en<=1` with the head's rd/data. A killed head gives `rf_en<=0` and the slot is still freed.
  - Otherwise `rf_en<=0`. `rf_wa`/`rf_wd` hold their previous values.
- `alu_valid` with `alu_rd == 0` is treated as no ALU request, and the FIFO may drain that cycle.
- Age rule: an ALU result accepted at edge t is younger than every LSU entry accepted at or before t.
- Kill rule: an ALU write to rd sets `killed` on every FIFO entry with a matching rd, including an entry pushed at the same edge. This stops the stale older value from later overwriting the newer one.
- Simultaneous LSU push and pop in one cycle is legal. Occupancy is unchanged.
- Bypass lookup (combinational): search live (valid, not killed) FIFO entries from youngest to oldest, then the output register if `rf_en`. The first match wins. `byp_addr == 0` gives `byp_hit=0`, `byp_data=0`. A miss gives `byp_data=0`.
- Starvation: continuous ALU traffic starves the FIFO. Upstream throttles using `lsu_ready` and `occupancy`; no internal fairness is provided.

## Timing
- Reset (asynchronous, effective immediately):
  - `rf_en=0`, `rf_wa=0`, `rf_wd=0`.
  - Pointers and `occupancy` = 0, all entries invalid.
  - `lsu_ready=0` while `rst` is high.
  - `byp_hit=0`.
- Reset mid-operation discards all queued results. There is no write on the next negedge.
- ALU latency: sampled at posedge t. Outputs are valid after t, and the register file commits at the negedge inside cycle t→t+1.
- LSU latency: accepted at edge t; popped at the earliest edge t+1 with no ALU request; committed at the negedge that follows.
- Outputs change only at posedge, so `rf_*` is stable at every register-file negedge.
- Full: with `occupancy==DEPTH`, `lsu_ready=0`. It rises one cycle after the first pop.

## Test plan
- Reset, then ALU `rd=5, data=0xDEADBEEF` at edge 1 -> after edge 1: `rf_en=1`, `rf_wa=5`, `rf_wd=0xDEADBEEF`; after edge 2 (idle): `rf_en=0`.
- LSU pushes rd=1..4 (data 0x11..0x44) on back-to-back cycles with ALU idle -> writes appear in order rd1..rd4, one per cycle starting the edge after the first push; occupancy peaks at 1.
- ALU valid every cycle while LSU pushes 5 entries -> `lsu_ready` drops after 4 accepts with `occupancy=4`; after ALU stops, 4 LSU writes drain in order and `lsu_ready` returns 1 the cycle after the first pop.
- LSU rd=7 `data=0x1` queued behind ALU traffic, then ALU rd=7 `data=0x2` -> `rf_wd=0x2` written; the queued entry pops with `rf_en=0`; a final `byp_addr=7` with an empty FIFO gives `byp_hit=0`.
- Queue LSU rd=3 `data=0xA` then rd=3 `data=0xB`, `byp_addr=3` -> `byp_hit=1`, `byp_data=0xB`. Separately, ALU rd=0 and LSU rd=0 -> `rf_en=0`, occupancy unchanged.
- Assert `rst` asynchronously with 3 entries queued and `rf_en=1` -> `rf_en`, `occupancy` and `lsu_ready` go to 0 before the next clock edge; no writes after release.
